// File: rtl/proc_pkg.sv
// proc_pkg: shared definitions for the filter datapath.
//   state_t     - sequencing states of the digit-serial arithmetic blocks
//   DEF_WIDTH   - default operand width (also used by the adder bench and filter top)
//   DEF_DIGIT   - default digit size for digit-serial blocks
package proc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DIGIT = 4;

endpackage

// File: rtl/digit_sub.sv
// digit_sub: combinational DIGIT-bit subtract with borrow chain.
//   a, b  - digit operands
//   bin   - borrow in from the less significant digit
//   d     - a - b - bin, modulo 2^DIGIT
//   bout  - borrow out to the next digit
module digit_sub #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic [DIGIT:0] full;

    // The extra top bit of a zero-extended subtraction is the borrow.
    assign full = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};
    assign d    = full[DIGIT-1:0];
    assign bout = full[DIGIT];

endmodule

// File: rtl/sub_serial.sv
// sub_serial: digit-serial subtractor, diff = opA - opB modulo 2^WIDTH,
// one DIGIT-bit slice per clock, valid/ready on both sides.
//   clk, rst_n           - clock, async active-low reset
//   in_valid/in_ready    - operand handshake (ready only in IDLE)
//   opA, opB             - minuend, subtrahend (captured on acceptance)
//   out_valid/out_ready  - result handshake (valid only in DONE)
//   diff, borrow, zero, ovf - registered result and flags
//
// state | meaning
// IDLE  | waiting for operands, in_ready = 1
// RUN   | processing slice cnt, one slice per clock
// DONE  | result held, out_valid = 1 until out_ready
//
// DIGIT must divide WIDTH.
module sub_serial
    import proc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [CW-1:0]      cnt;
    logic               bin;

    logic [DIGIT-1:0]   sa;
    logic [DIGIT-1:0]   sb;
    logic [DIGIT-1:0]   sd;
    logic               sbo;
    logic [WIDTH-1:0]   diff_nx;
    logic               last;

    always_comb begin
        sa      = a_q[int'(cnt)*DIGIT +: DIGIT];
        sb      = b_q[int'(cnt)*DIGIT +: DIGIT];
        diff_nx = diff;
        diff_nx[int'(cnt)*DIGIT +: DIGIT] = sd;
        last    = (cnt == CW'(N-1));
    end

    digit_sub #(.DIGIT(DIGIT)) u_digit_sub (
        .a    (sa),
        .b    (sb),
        .bin  (bin),
        .d    (sd),
        .bout (sbo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            bin       <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= opA;
                        b_q      <= opB;
                        cnt      <= '0;
                        bin      <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    diff <= diff_nx;
                    bin  <= sbo;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        // Flags come from the fully assembled result, including this slice.
                        borrow    <= sbo;
                        zero      <= (diff_nx == '0);
                        ovf       <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                     (diff_nx[WIDTH-1] != a_q[WIDTH-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_serial.sv
module tb_sub_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        borrow;
    logic        zero;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sub_serial #(.WIDTH(32), .DIGIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opA       (opA),
        .opB       (opB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present operands for one accepting edge, then wait for out_valid.
    // Returns with time at #1 after the edge on which out_valid was first seen.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        opA      = a;
        opB      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opA      = 32'hDEAD_BEEF;
        opB      = 32'h0BAD_F00D;
        chk("in_ready_low_in_run", {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic release_op;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_after_handoff", {31'd0, out_valid}, 32'd0);
        chk("in_ready_after_handoff", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [31:0] ed,
                                input logic eb, input logic ez, input logic eo);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_borrow"}, {31'd0, borrow}, {31'd0, eb});
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opA       = '0;
        opB       = '0;
        #12;
        check_result("reset", 32'd0, 1'b0, 1'b0, 1'b0);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        #3;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // 1. basic subtract, latency N = 8
        start_op(32'd5, 32'd3, lat);
        chk("basic_latency", lat, 32'd8);
        check_result("basic", 32'd2, 1'b0, 1'b0, 1'b0);
        release_op();

        // 2. unsigned borrow
        start_op(32'd3, 32'd5, lat);
        check_result("borrow", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        release_op();

        // 3. signed overflow
        start_op(32'h8000_0000, 32'd1, lat);
        check_result("ovf", 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
        release_op();

        // 4. equal operands
        start_op(32'h1234_5678, 32'h1234_5678, lat);
        check_result("equal", 32'd0, 1'b0, 1'b1, 1'b0);
        release_op();

        // Positive minus negative overflow, full borrow chain
        start_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, lat);
        check_result("ovf_pos", 32'h8000_0000, 1'b1, 1'b0, 1'b1);
        release_op();

        // 5. backpressure with new operands pending
        start_op(32'h0000_1000, 32'd1, lat);
        check_result("bp_first", 32'h0000_0FFF, 1'b0, 1'b0, 1'b0);
        opA      = 32'h10;
        opB      = 32'h1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_diff_stable", diff, 32'h0000_0FFF);
            chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_in_ready_rise", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opA      = 32'hFFFF_FFFF;
        opB      = 32'hFFFF_FFFF;
        chk("bp_accepted", {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp_latency", lat, 32'd8);
        check_result("bp_second", 32'h0000_000F, 1'b0, 1'b0, 1'b0);
        release_op();

        // 6. reset while slice 3 is being processed
        @(negedge clk);
        opA      = 32'hFFFF_FFFF;
        opB      = 32'h1111_1111;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_result("midrst", 32'd0, 1'b0, 1'b0, 1'b0);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        start_op(32'd100, 32'd58, lat);
        chk("post_rst_latency", lat, 32'd8);
        check_result("post_rst", 32'd42, 1'b0, 1'b0, 1'b0);
        release_op();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
